cm3_matrix_err_slave: RTL and testbench
=======================================

// Module: cm3_matrix_err_slave
// PURPOSE
//  Parametrised default/error slave for the cm3 bus matrix: answers any AHB access not claimed by a real slave.
//  Adds programmable wait states, RAZ/WI or ERROR mode, a saturating fault counter and a fault IRQ pulse.
//  Sits on each matrix output stage's default decode slot.
// PARAMETERS
//  ADDR_WIDTH   32  width of HADDR and of the captured fault address
//  DATA_WIDTH   32  width of HRDATA; driven all-zero
//  WAIT_STATES  0   OKAY wait cycles inserted before the response, 0..15
//  MODE         0   0 = two-cycle ERROR response; 1 = RAZ/WI (OKAY, read data zero)
//  CNT_WIDTH    8   width of the fault counter
// PORTS
//  HCLK        in   1           AHB clock
//  HRESET      in   1           synchronous, active-high reset
//  HSEL        in   1           slave select
//  HTRANS      in   2           transfer type; HTRANS[1]=1 for NONSEQ/SEQ
//  HREADY      in   1           bus transfer done
//  HADDR       in   ADDR_WIDTH  address phase address
//  HWRITE      in   1           address phase direction
//  CNT_CLR     in   1           clears fault counter and capture registers
//  HREADYOUT   out  1           ready feedback
//  HRESP       out  2           00 OKAY, 01 ERROR
//  HRDATA      out  DATA_WIDTH  constant zero
//  FAULT_IRQ   out  1           one-cycle pulse per completed faulting transfer
//  FAULT_CNT   out  CNT_WIDTH   saturating count of faulting transfers
// BEHAVIOUR
//  - One clock (HCLK). Reset is synchronous and active-high (HRESET), sampled on HCLK rising edge only.
//  - Reset values: HREADYOUT=1, HRESP=00, HRDATA=0, FAULT_IRQ=0, FAULT_CNT=0, state=IDLE.
//  - Valid access: HSEL & HREADY & HTRANS[1], sampled in the address phase.
//  - IDLE/BUSY or unselected: zero-wait OKAY; state unchanged.
//  - FSM states: IDLE, WAIT, ERR1, ERR2.
//  - IDLE, valid access:
//    WAIT_STATES>0 -> WAIT, counter=WAIT_STATES-1.
//    WAIT_STATES=0 -> ERR1 (MODE 0) or OKAY completion next cycle (MODE 1).
//  - WAIT: HREADYOUT=0, HRESP=00. Counter decrements each cycle.
//    At 0 -> ERR1 (MODE 0), or a single HREADYOUT=1 OKAY cycle, then IDLE (MODE 1).
//  - ERR1: HREADYOUT=0, HRESP=01. Always -> ERR2.
//  - ERR2: HREADYOUT=1, HRESP=01.
//    New valid access sampled in ERR2 is accepted and follows the IDLE rules; otherwise -> IDLE.
//  - Latency, MODE 0: data phase completes WAIT_STATES+2 cycles after the address phase.
//  - Latency, MODE 1: data phase completes WAIT_STATES+1 cycles after the address phase; minimum 1.
//  - Back-to-back accesses: in MODE 1 with WAIT_STATES=0, every cycle may carry a new access.
//  - FAULT_IRQ: high the cycle after the completing cycle (ERR2, or the MODE 1 OKAY cycle).
//  - FAULT_CNT: +1 per completed access, saturates at 2^CNT_WIDTH-1, no wrap.
//  - CNT_CLR concurrent with an increment: clear wins; that fault is dropped.
//  - HRESET mid-transfer: returns to IDLE with reset values next edge; in-flight response abandoned.
//  - Masters must ignore any abandoned response.
// CONFIGURATION
//  - Macro ERR_SLV_FAULT_LOG_EN, when defined, adds:
//    FAULT_ADDR (out, ADDR_WIDTH) and FAULT_WR (out, 1).
//    Both capture HADDR/HWRITE of the first fault after reset or CNT_CLR; held until cleared.
//    FAULT_VLD (out, 1) marks the capture as valid.
//  - Without the macro, these ports and registers do not exist. All other behaviour is identical.
// STRUCTURE
//  - Shared package cm3_matrix_pkg holds:
//    HRESP encodings RSP_OKAY=2'b00, RSP_ERROR=2'b01;
//    FSM state encodings (ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2, 2-bit);
//    HTRANS encodings.
//  - One sub-module, cm3_matrix_err_log: fault counter, IRQ pulse and the optional capture registers.
//  - The top level holds the response FSM and the wait counter.
// TESTING
//  - Reset: HRESET=1 for 2 cycles -> HREADYOUT=1, HRESP=00, FAULT_CNT=0, FAULT_IRQ=0.
//  - MODE 0, WAIT_STATES=0, NONSEQ read to 0x4000_0010:
//    next cycle HREADYOUT=0/HRESP=01; then HREADYOUT=1/HRESP=01; FAULT_IRQ pulse; FAULT_CNT=1.
//  - MODE 0, WAIT_STATES=3: 3 cycles HREADYOUT=0/HRESP=00, then ERR1, then ERR2; total 5-cycle data phase.
//  - MODE 1, WAIT_STATES=0, four back-to-back NONSEQ writes: each completes OKAY in 1 cycle; FAULT_CNT=4.
//  - CNT_WIDTH=2, five faults -> FAULT_CNT saturates at 3.
//    CNT_CLR on the same cycle as a sixth fault -> FAULT_CNT=0.
//  - ERR_SLV_FAULT_LOG_EN, faults at 0x100 (write) then 0x200 (read):
//    FAULT_ADDR=0x100, FAULT_WR=1, FAULT_VLD=1.
//    HRESET asserted in ERR1 -> IDLE and reset values next cycle.

Source files
------------

// File: rtl/cm3_matrix_pkg.sv
// Shared encodings for the cm3 bus matrix: HRESP, HTRANS and the default-slave FSM states.
package cm3_matrix_pkg;

    localparam logic [1:0] RSP_OKAY  = 2'b00;
    localparam logic [1:0] RSP_ERROR = 2'b01;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam int unsigned WAIT_CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_ERR1 = 2'b10,
        ST_ERR2 = 2'b11
    } err_state_e;

    // Address-phase qualifier: only NONSEQ/SEQ transfers need a data-phase response.
    function automatic logic ahb_valid(input logic       hsel,
                                       input logic       hready,
                                       input logic [1:0] htrans);
        logic active;
        unique case (htrans)
            HTRANS_NONSEQ, HTRANS_SEQ: active = 1'b1;
            HTRANS_IDLE, HTRANS_BUSY:  active = 1'b0;
            default:                   active = 1'b0;
        endcase
        return hsel && hready && active;
    endfunction

endpackage

// File: rtl/cm3_matrix_err_log.sv
// Fault bookkeeping for the default slave: saturating counter, IRQ pulse and, when
// ERR_SLV_FAULT_LOG_EN is defined, first-fault address/direction capture.
module cm3_matrix_err_log
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 8
)(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clr_i,
    input  logic                  complete_i,
`ifdef ERR_SLV_FAULT_LOG_EN
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic                  wr_i,
    output logic [ADDR_WIDTH-1:0] fault_addr_o,
    output logic                  fault_wr_o,
    output logic                  fault_vld_o,
`endif
    output logic                  irq_o,
    output logic [CNT_WIDTH-1:0]  cnt_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic                 irq_q;
    logic [CNT_WIDTH-1:0] cnt_q;

    // A clear coinciding with a completion drops that fault from the count.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            irq_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            irq_q <= complete_i;
            if (clr_i) begin
                cnt_q <= '0;
            end else if (complete_i && (cnt_q != CNT_MAX)) begin
                cnt_q <= cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    assign irq_o = irq_q;
    assign cnt_o = cnt_q;

`ifdef ERR_SLV_FAULT_LOG_EN
    logic [ADDR_WIDTH-1:0] fault_addr_q;
    logic                  fault_wr_q;
    logic                  fault_vld_q;

    // Only the first fault after reset/clear is kept.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            fault_addr_q <= '0;
            fault_wr_q   <= 1'b0;
            fault_vld_q  <= 1'b0;
        end else if (complete_i && !fault_vld_q) begin
            fault_addr_q <= addr_i;
            fault_wr_q   <= wr_i;
            fault_vld_q  <= 1'b1;
        end
    end

    assign fault_addr_o = fault_addr_q;
    assign fault_wr_o   = fault_wr_q;
    assign fault_vld_o  = fault_vld_q;
`endif

endmodule

// File: rtl/cm3_matrix_err_slave.sv
// Default/error slave for a cm3 matrix output stage: wait states, ERROR or RAZ/WI response.
// Optional fault address logging is enabled by defining ERR_SLV_FAULT_LOG_EN.
module cm3_matrix_err_slave
    import cm3_matrix_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned WAIT_STATES = 0,
    parameter int unsigned MODE        = 0,
    parameter int unsigned CNT_WIDTH   = 8
)(
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [1:0]            HTRANS,
    input  logic                  HREADY,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic                  HWRITE,
    input  logic                  CNT_CLR,
    output logic                  HREADYOUT,
    output logic [1:0]            HRESP,
    output logic [DATA_WIDTH-1:0] HRDATA,
    output logic                  FAULT_IRQ,
    output logic [CNT_WIDTH-1:0]  FAULT_CNT
`ifdef ERR_SLV_FAULT_LOG_EN
    ,
    output logic [ADDR_WIDTH-1:0] FAULT_ADDR,
    output logic                  FAULT_WR,
    output logic                  FAULT_VLD
`endif
);

    err_state_e            state_q;
    logic [WAIT_CNT_W-1:0] wait_cnt_q;
    logic                  done_q;
    logic                  hreadyout_q;
    logic [1:0]            hresp_q;
    logic                  valid_c;
    logic                  accept_c;
    logic                  complete_c;

    assign valid_c    = ahb_valid(HSEL, HREADY, HTRANS);
    assign accept_c   = valid_c && ((state_q == ST_IDLE) || (state_q == ST_ERR2));
    // done_q marks the RAZ/WI OKAY completion cycle, which otherwise looks like IDLE.
    assign complete_c = (state_q == ST_ERR2) || done_q;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q     <= ST_IDLE;
            wait_cnt_q  <= '0;
            done_q      <= 1'b0;
            hreadyout_q <= 1'b1;
            hresp_q     <= RSP_OKAY;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_WAIT: begin
                    if (wait_cnt_q == '0) begin
                        if (MODE == 0) begin
                            state_q     <= ST_ERR1;
                            hreadyout_q <= 1'b0;
                            hresp_q     <= RSP_ERROR;
                        end else begin
                            state_q     <= ST_IDLE;
                            hreadyout_q <= 1'b1;
                            hresp_q     <= RSP_OKAY;
                            done_q      <= 1'b1;
                        end
                    end else begin
                        wait_cnt_q <= wait_cnt_q - WAIT_CNT_W'(1);
                    end
                end
                ST_ERR1: begin
                    state_q     <= ST_ERR2;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= RSP_ERROR;
                end
                default: begin
                    // IDLE and ERR2 both take a new access with the same rules.
                    if (accept_c) begin
                        if (WAIT_STATES > 0) begin
                            state_q     <= ST_WAIT;
                            wait_cnt_q  <= WAIT_CNT_W'(WAIT_STATES - 1);
                            hreadyout_q <= 1'b0;
                            hresp_q     <= RSP_OKAY;
                        end else if (MODE == 0) begin
                            state_q     <= ST_ERR1;
                            hreadyout_q <= 1'b0;
                            hresp_q     <= RSP_ERROR;
                        end else begin
                            state_q     <= ST_IDLE;
                            hreadyout_q <= 1'b1;
                            hresp_q     <= RSP_OKAY;
                            done_q      <= 1'b1;
                        end
                    end else begin
                        state_q     <= ST_IDLE;
                        hreadyout_q <= 1'b1;
                        hresp_q     <= RSP_OKAY;
                    end
                end
            endcase
        end
    end

    assign HREADYOUT = hreadyout_q;
    assign HRESP     = hresp_q;
    assign HRDATA    = '0;

`ifdef ERR_SLV_FAULT_LOG_EN
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  wr_q;

    // Hold the address phase of the in-flight access until its completion is logged.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            addr_q <= '0;
            wr_q   <= 1'b0;
        end else if (accept_c) begin
            addr_q <= HADDR;
            wr_q   <= HWRITE;
        end
    end
`else
    logic unused_addr_c;
    assign unused_addr_c = ^{HADDR, HWRITE};
`endif

    cm3_matrix_err_log #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_log (
        .clk_i        (HCLK),
        .rst_i        (HRESET),
        .clr_i        (CNT_CLR),
        .complete_i   (complete_c),
`ifdef ERR_SLV_FAULT_LOG_EN
        .addr_i       (addr_q),
        .wr_i         (wr_q),
        .fault_addr_o (FAULT_ADDR),
        .fault_wr_o   (FAULT_WR),
        .fault_vld_o  (FAULT_VLD),
`endif
        .irq_o        (FAULT_IRQ),
        .cnt_o        (FAULT_CNT)
    );

endmodule

// File: tb/tb_cm3_matrix_err_slave.sv
// Self-checking bench for cm3_matrix_err_slave: four parameterisations driven side by side.
module tb_cm3_matrix_err_slave;

    localparam int unsigned N = 4;

    function automatic int unsigned mode_of(input int unsigned i);
        return (i >= 2) ? 1 : 0;
    endfunction
    function automatic int unsigned ws_of(input int unsigned i);
        return (i == 1) ? 3 : (i == 3) ? 2 : 0;
    endfunction
    function automatic int unsigned cw_of(input int unsigned i);
        return (i == 3) ? 2 : 8;
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        hreset[N], hsel[N], hready[N], hwrite[N], cnt_clr[N];
    logic [1:0]  htrans[N];
    logic [31:0] haddr[N];
    logic        hreadyout[N], irq[N];
    logic [1:0]  hresp[N];
    logic [31:0] hrdata[N];
    logic [7:0]  fcnt[N];
`ifdef ERR_SLV_FAULT_LOG_EN
    logic [31:0] faddr[N];
    logic        fwr[N], fvld[N];
`endif

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int unsigned CW = cw_of(g);
        logic [CW-1:0] cnt_w;
        cm3_matrix_err_slave #(
            .ADDR_WIDTH  (32),
            .DATA_WIDTH  (32),
            .WAIT_STATES (ws_of(g)),
            .MODE        (mode_of(g)),
            .CNT_WIDTH   (CW)
        ) u_dut (
            .HCLK       (clk),
            .HRESET     (hreset[g]),
            .HSEL       (hsel[g]),
            .HTRANS     (htrans[g]),
            .HREADY     (hready[g]),
            .HADDR      (haddr[g]),
            .HWRITE     (hwrite[g]),
            .CNT_CLR    (cnt_clr[g]),
            .HREADYOUT  (hreadyout[g]),
            .HRESP      (hresp[g]),
            .HRDATA     (hrdata[g]),
            .FAULT_IRQ  (irq[g]),
            .FAULT_CNT  (cnt_w)
`ifdef ERR_SLV_FAULT_LOG_EN
            ,
            .FAULT_ADDR (faddr[g]),
            .FAULT_WR   (fwr[g]),
            .FAULT_VLD  (fvld[g])
`endif
        );
        assign fcnt[g] = 8'(cnt_w);
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Stimulus for the next edge, staged by the caller.
    logic        nxt_rst[N], nxt_sel[N], nxt_wr[N], nxt_clr[N], nxt_rdy[N];
    logic [1:0]  nxt_trans[N];
    logic [31:0] nxt_addr[N];

    // Reference model: remaining data-phase cycles of the in-flight access.
    int unsigned rem[N];
    int unsigned exp_cnt[N];
    logic        exp_irq[N];
`ifdef ERR_SLV_FAULT_LOG_EN
    logic        exp_vld[N], exp_wr[N], infl_wr[N];
    logic [31:0] exp_addr[N], infl_addr[N];
`endif

    task automatic idle_all();
        for (int i = 0; i < N; i++) begin
            nxt_rst[i]   = 1'b0;
            nxt_sel[i]   = 1'b0;
            nxt_trans[i] = 2'b00;
            nxt_addr[i]  = 32'h0;
            nxt_wr[i]    = 1'b0;
            nxt_clr[i]   = 1'b0;
            nxt_rdy[i]   = 1'b1;
        end
    endtask

    task automatic model_reset(input int i);
        rem[i]     = 0;
        exp_cnt[i] = 0;
        exp_irq[i] = 1'b0;
`ifdef ERR_SLV_FAULT_LOG_EN
        exp_vld[i]  = 1'b0;
        exp_addr[i] = 32'h0;
        exp_wr[i]   = 1'b0;
`endif
    endtask

    // Check the current cycle's outputs, then apply staged inputs and advance the model.
    task automatic step();
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            logic        e_rdy, hr, completing;
            logic [1:0]  e_resp;
            int unsigned len;
            e_rdy  = (rem[i] <= 1);
            e_resp = (mode_of(i) == 0 && (rem[i] == 1 || rem[i] == 2)) ? 2'b01 : 2'b00;
            chk($sformatf("hreadyout[%0d]", i), 32'(hreadyout[i]), 32'(e_rdy));
            chk($sformatf("hresp[%0d]", i), 32'(hresp[i]), 32'(e_resp));
            chk($sformatf("hrdata[%0d]", i), hrdata[i], 32'h0);
            chk($sformatf("irq[%0d]", i), 32'(irq[i]), 32'(exp_irq[i]));
            chk($sformatf("cnt[%0d]", i), 32'(fcnt[i]), exp_cnt[i]);
`ifdef ERR_SLV_FAULT_LOG_EN
            chk($sformatf("vld[%0d]", i), 32'(fvld[i]), 32'(exp_vld[i]));
            if (exp_vld[i]) begin
                chk($sformatf("faddr[%0d]", i), faddr[i], exp_addr[i]);
                chk($sformatf("fwr[%0d]", i), 32'(fwr[i]), 32'(exp_wr[i]));
            end
`endif
            hr = (rem[i] == 0) ? nxt_rdy[i] : (rem[i] == 1);
            hreset[i]  = nxt_rst[i];
            hsel[i]    = nxt_sel[i];
            htrans[i]  = nxt_trans[i];
            haddr[i]   = nxt_addr[i];
            hwrite[i]  = nxt_wr[i];
            cnt_clr[i] = nxt_clr[i];
            hready[i]  = hr;
            completing = (rem[i] == 1);
            if (nxt_rst[i]) begin
                model_reset(i);
            end else begin
                exp_irq[i] = completing;
                if (nxt_clr[i]) begin
                    exp_cnt[i] = 0;
`ifdef ERR_SLV_FAULT_LOG_EN
                    exp_vld[i]  = 1'b0;
                    exp_addr[i] = 32'h0;
                    exp_wr[i]   = 1'b0;
`endif
                end else if (completing) begin
                    if (exp_cnt[i] < (1 << cw_of(i)) - 1) exp_cnt[i]++;
`ifdef ERR_SLV_FAULT_LOG_EN
                    if (!exp_vld[i]) begin
                        exp_vld[i]  = 1'b1;
                        exp_addr[i] = infl_addr[i];
                        exp_wr[i]   = infl_wr[i];
                    end
`endif
                end
                if (rem[i] > 0) rem[i]--;
                if (nxt_sel[i] && hr && nxt_trans[i][1]) begin
                    len = ws_of(i) + ((mode_of(i) == 0) ? 2 : 1);
                    rem[i] = len;
`ifdef ERR_SLV_FAULT_LOG_EN
                    infl_addr[i] = nxt_addr[i];
                    infl_wr[i]   = nxt_wr[i];
`endif
                end
            end
        end
    endtask

    task automatic do_access(input int i, input logic [31:0] addr, input logic wr);
        idle_all();
        nxt_sel[i]   = 1'b1;
        nxt_trans[i] = 2'b10;
        nxt_addr[i]  = addr;
        nxt_wr[i]    = wr;
        step();
        idle_all();
        for (int k = 0; k < 32 && rem[i] != 0; k++) step();
    endtask

    initial begin
        idle_all();
        for (int i = 0; i < N; i++) begin
            hreset[i] = 1'b1; hsel[i] = 1'b0; htrans[i] = 2'b00; hready[i] = 1'b1;
            haddr[i] = 32'h0; hwrite[i] = 1'b0; cnt_clr[i] = 1'b0;
            nxt_rst[i] = 1'b1;
`ifdef ERR_SLV_FAULT_LOG_EN
            infl_addr[i] = 32'h0;
            infl_wr[i]   = 1'b0;
`endif
            model_reset(i);
        end
        @(posedge clk);
        step();
        idle_all();
        step();
        chk("reset_rdy", 32'(hreadyout[0]), 32'd1);
        chk("reset_resp", 32'(hresp[1]), 32'd0);
        chk("reset_cnt", 32'(fcnt[2]), 32'd0);
        chk("reset_irq", 32'(irq[3]), 32'd0);

        // MODE 0, no wait states: ERR1 then ERR2.
        idle_all();
        nxt_sel[0] = 1'b1; nxt_trans[0] = 2'b10; nxt_addr[0] = 32'h4000_0010;
        step();
        idle_all();
        step();
        chk("m0_err1_rdy", 32'(hreadyout[0]), 32'd0);
        chk("m0_err1_resp", 32'(hresp[0]), 32'd1);
        step();
        chk("m0_err2_rdy", 32'(hreadyout[0]), 32'd1);
        chk("m0_err2_resp", 32'(hresp[0]), 32'd1);
        step();
        chk("m0_irq", 32'(irq[0]), 32'd1);
        chk("m0_cnt", 32'(fcnt[0]), 32'd1);

        // MODE 0, three wait states: five-cycle data phase.
        idle_all();
        nxt_sel[1] = 1'b1; nxt_trans[1] = 2'b10; nxt_addr[1] = 32'h4000_0020;
        step();
        idle_all();
        for (int k = 0; k < 3; k++) begin
            step();
            chk("ws3_wait", {30'h0, hreadyout[1], 1'b0} | 32'(hresp[1]), 32'd0);
        end
        step();
        chk("ws3_err1", {30'h0, hreadyout[1], 1'b0} | 32'(hresp[1]), 32'd1);
        step();
        chk("ws3_err2", {30'h0, hreadyout[1], 1'b0} | 32'(hresp[1]), 32'd3);

        // MODE 1, back-to-back single-cycle writes.
        for (int k = 0; k < 4; k++) begin
            idle_all();
            nxt_sel[2] = 1'b1; nxt_trans[2] = 2'b10; nxt_addr[2] = 32'(k * 4); nxt_wr[2] = 1'b1;
            step();
        end
        idle_all();
        step();
        step();
        chk("b2b_cnt", 32'(fcnt[2]), 32'd4);

        // 2-bit counter saturates, then a clear races the sixth fault.
        for (int k = 0; k < 5; k++) do_access(3, 32'h300 + 32'(k), 1'b0);
        step();
        chk("sat_cnt", 32'(fcnt[3]), 32'd3);
        idle_all();
        nxt_sel[3] = 1'b1; nxt_trans[3] = 2'b11;
        step();
        idle_all();
        for (int k = 0; k < 16 && rem[3] != 1; k++) step();
        nxt_clr[3] = 1'b1;
        step();
        idle_all();
        step();
        chk("clr_wins_cnt", 32'(fcnt[3]), 32'd0);

        // First-fault capture after a clear.
        idle_all();
        nxt_clr[0] = 1'b1;
        step();
        do_access(0, 32'h100, 1'b1);
        do_access(0, 32'h200, 1'b0);
        step();
        chk("log_cnt", 32'(fcnt[0]), 32'd2);
`ifdef ERR_SLV_FAULT_LOG_EN
        chk("log_addr", faddr[0], 32'h100);
        chk("log_wr", 32'(fwr[0]), 32'd1);
        chk("log_vld", 32'(fvld[0]), 32'd1);
`endif

        // Reset during ERR1 abandons the response.
        idle_all();
        nxt_sel[0] = 1'b1; nxt_trans[0] = 2'b10; nxt_addr[0] = 32'h400;
        step();
        idle_all();
        nxt_rst[0] = 1'b1;
        step();
        idle_all();
        step();
        chk("rst_err1_rdy", 32'(hreadyout[0]), 32'd1);
        chk("rst_err1_resp", 32'(hresp[0]), 32'd0);
        chk("rst_err1_cnt", 32'(fcnt[0]), 32'd0);

        // Randomised traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                nxt_rst[i]   = ($urandom_range(0, 99) == 0);
                nxt_sel[i]   = ($urandom_range(0, 3) != 0);
                nxt_trans[i] = 2'($urandom_range(0, 3));
                nxt_addr[i]  = $urandom;
                nxt_wr[i]    = 1'($urandom_range(0, 1));
                nxt_clr[i]   = ($urandom_range(0, 31) == 0);
                nxt_rdy[i]   = ($urandom_range(0, 3) != 0);
            end
            step();
        end
        idle_all();
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
